// File: rtl/sel_rr_arbiter.sv
// Request arbiter feeding the 3:1 select mux: registered one-hot grant plus binary select,
// fixed-priority or round-robin choice, bounded ownership under contention, sticky sanity flags.
module sel_rr_arbiter #(
  parameter int N        = 3,
  parameter int SELW     = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            mode,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] sel,
  output logic            sel_vld,
  output logic            err_multi,
  output logic            err_range
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          st, st_nx;
  logic [HW-1:0]   hold_cnt, hold_nx;
  logic [SELW-1:0] rr_ptr, rr_nx, sel_nx, win;
  logic [N-1:0]    gnt_nx, cand, others;
  logic            vld_nx, do_arb, owner_req;

  // Fixed priority scans from index 0; round-robin scans from the slot after the last winner.
  function automatic logic [SELW-1:0] pick(input logic [N-1:0] r, input logic rr,
                                           input logic [SELW-1:0] ptr);
    logic [SELW-1:0] w;
    logic [N-1:0]    bit_i;
    logic            found;
    int              start, idx;
    w     = '0;
    found = 1'b0;
    start = rr ? (int'(ptr) + 1) % N : 0;
    for (int i = 0; i < N; i++) begin
      idx   = (start + i) % N;
      bit_i = N'(1) << idx;
      if (!found && ((r & bit_i) != '0)) begin
        w     = SELW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  assign owner_req = |(req & gnt);
  assign others    = req & ~gnt;

  always_comb begin
    st_nx   = st;
    gnt_nx  = gnt;
    sel_nx  = sel;
    vld_nx  = sel_vld;
    hold_nx = hold_cnt;
    rr_nx   = rr_ptr;
    cand    = '0;
    do_arb  = 1'b0;
    case (st)
      IDLE: begin
        if (|req) begin
          cand   = req;
          do_arb = 1'b1;
        end else begin
          gnt_nx  = '0;
          vld_nx  = 1'b0;
          hold_nx = '0;
        end
      end
      OWN: begin
        if (owner_req) begin
          if (others == '0) begin
            hold_nx = (hold_cnt == HW'(HOLD_MAX)) ? hold_cnt : hold_cnt + HW'(1);
          end else if (hold_cnt >= HW'(HOLD_MAX - 1)) begin
            // Owner has used its share while someone waits: hand over, owner excluded.
            cand   = others;
            do_arb = 1'b1;
          end else begin
            hold_nx = hold_cnt + HW'(1);
          end
        end else if (|req) begin
          cand   = req;
          do_arb = 1'b1;
        end else begin
          st_nx   = IDLE;
          gnt_nx  = '0;
          vld_nx  = 1'b0;
          hold_nx = '0;
        end
      end
      default: st_nx = IDLE;
    endcase
    win = pick(cand, mode, rr_ptr);
    if (do_arb) begin
      st_nx   = OWN;
      gnt_nx  = N'(1) << win;
      sel_nx  = win;
      vld_nx  = 1'b1;
      rr_nx   = win;
      hold_nx = '0;
    end
  end

  // Registered grant stage
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      sel_vld   <= 1'b0;
      hold_cnt  <= '0;
      rr_ptr    <= SELW'(N - 1);
      err_multi <= 1'b0;
      err_range <= 1'b0;
    end else begin
      st        <= st_nx;
      gnt       <= gnt_nx;
      sel       <= sel_nx;
      sel_vld   <= vld_nx;
      hold_cnt  <= hold_nx;
      rr_ptr    <= rr_nx;
      err_multi <= err_multi | (sel_vld & ~onehot(gnt));
      err_range <= err_range | (sel_vld & (int'(sel) >= N));
    end
  end

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Bench for sel_rr_arbiter: two instances (HOLD_MAX 8 and 4) on shared stimulus, directed
// vector table, hand sequences for rotation/anti-starvation, and a randomized reference model.
module tb_sel_rr_arbiter;

  localparam int N = 3;

  logic       clk, rst, mode;
  logic [2:0] req;
  logic [2:0] gnt_o [2];
  logic [1:0] sel_o [2];
  logic       vld_o [2];
  logic       em_o  [2];
  logic       er_o  [2];

  int total = 0;
  int bad   = 0;

  sel_rr_arbiter #(.N(3), .SELW(2), .HOLD_MAX(8)) u8 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gnt_o[0]), .sel(sel_o[0]), .sel_vld(vld_o[0]),
    .err_multi(em_o[0]), .err_range(er_o[0]));

  sel_rr_arbiter #(.N(3), .SELW(2), .HOLD_MAX(4)) u4 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gnt_o[1]), .sel(sel_o[1]), .sel_vld(vld_o[1]),
    .err_multi(em_o[1]), .err_range(er_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner (-1 = none), last select, last winner, cycles owned so far.
  int m_hold  [2] = '{8, 4};
  int m_owner [2] = '{-1, -1};
  int m_sel   [2] = '{0, 0};
  int m_ptr   [2] = '{N - 1, N - 1};
  int m_age   [2] = '{0, 0};

  int run    [2] = '{0, 0};
  int maxrun [2] = '{0, 0};
  logic [2:0] lastg [2];

  function automatic int mpick(input logic [2:0] q, input logic m, input int ptr);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = m ? (ptr + 1 + k) % N : k;
      if (((q >> idx) & 3'b001) != 3'b000) return idx;
    end
    return -1;
  endfunction

  task automatic mgrant(input int k, input int w);
    m_owner[k] = w;
    m_sel[k]   = w;
    m_ptr[k]   = w;
    m_age[k]   = 1;
  endtask

  task automatic model_step(input int k);
    logic [2:0] mine, rest;
    if (rst) begin
      m_owner[k] = -1; m_sel[k] = 0; m_ptr[k] = N - 1; m_age[k] = 0;
    end else if (m_owner[k] < 0) begin
      if (req != 3'b000) mgrant(k, mpick(req, mode, m_ptr[k]));
    end else begin
      mine = 3'b001 << m_owner[k];
      rest = req & ~mine;
      if ((req & mine) != 3'b000) begin
        if (rest != 3'b000 && m_age[k] >= m_hold[k]) mgrant(k, mpick(rest, mode, m_ptr[k]));
        else m_age[k]++;
      end else if (req != 3'b000) begin
        mgrant(k, mpick(req, mode, m_ptr[k]));
      end else begin
        m_owner[k] = -1;
      end
    end
  endtask

  task automatic check_dut(input int k);
    logic [7:0] act, expv;
    logic [2:0] eg;
    eg   = (m_owner[k] >= 0) ? (3'b001 << m_owner[k]) : 3'b000;
    act  = {gnt_o[k], sel_o[k], vld_o[k], em_o[k], er_o[k]};
    expv = {eg, 2'(m_sel[k]), (m_owner[k] >= 0), 2'b00};
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL model[h=%0d] t=%0t gnt/sel/vld/em/er actual=%b required=%b",
               m_hold[k], $time, act, expv);
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, expv);
    end
  endtask

  // One clock: track contention runs for the current cycle, step models, compare.
  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        run[k] = 0; lastg[k] = 3'b000;
      end else if (vld_o[k] && ((req & ~gnt_o[k]) != 3'b000)) begin
        run[k]   = (gnt_o[k] == lastg[k]) ? run[k] + 1 : 1;
        lastg[k] = gnt_o[k];
        if (run[k] > maxrun[k]) maxrun[k] = run[k];
      end else begin
        run[k] = 0; lastg[k] = 3'b000;
      end
    end
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       mode;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       vld;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int eo;
    rst = 1'b1; req = 3'b000; mode = 1'b0;
    lastg[0] = 3'b000; lastg[1] = 3'b000;

    vecs[0]  = '{1'b1, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 3'b110, 1'b0, 3'b010, 2'd1, 1'b1};
    vecs[7]  = '{1'b0, 3'b100, 1'b0, 3'b100, 2'd2, 1'b1};
    vecs[8]  = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd2, 1'b0};
    vecs[9]  = '{1'b0, 3'b100, 1'b0, 3'b100, 2'd2, 1'b1};
    vecs[10] = '{1'b0, 3'b101, 1'b0, 3'b100, 2'd2, 1'b1};
    vecs[11] = '{1'b1, 3'b101, 1'b0, 3'b000, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 3'b101, 1'b1, 3'b001, 2'd0, 1'b1};
    vecs[13] = '{1'b0, 3'b110, 1'b1, 3'b010, 2'd1, 1'b1};
    vecs[14] = '{1'b1, 3'b110, 1'b1, 3'b000, 2'd0, 1'b0};
    vecs[15] = '{1'b0, 3'b110, 1'b1, 3'b010, 2'd1, 1'b1};
    vecs[16] = '{1'b0, 3'b000, 1'b1, 3'b000, 2'd1, 1'b0};

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; req = vecs[i].req; mode = vecs[i].mode;
      cycle();
      chk($sformatf("vec%0d.gnt", i), int'(gnt_o[0]), int'(vecs[i].gnt));
      chk($sformatf("vec%0d.sel", i), int'(sel_o[0]), int'(vecs[i].sel));
      chk($sformatf("vec%0d.vld", i), int'(vld_o[0]), int'(vecs[i].vld));
    end

    // Round-robin rotation under full load, 8-cycle shares back to back.
    rst = 1'b1; req = 3'b000; cycle();
    rst = 1'b0; req = 3'b111; mode = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      cycle();
      eo = ((c - 1) / 8) % 3;
      chk($sformatf("rr_c%0d.sel", c), int'(sel_o[0]), eo);
      chk($sformatf("rr_c%0d.gnt", c), int'(gnt_o[0]), 1 << eo);
      chk($sformatf("rr_c%0d.vld", c), int'(vld_o[0]), 1);
    end

    // Fixed priority cannot starve requester 1 with a 4-cycle limit.
    rst = 1'b1; req = 3'b000; mode = 1'b0; cycle();
    rst = 1'b0; req = 3'b011;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      eo = ((c - 1) / 4) % 2;
      chk($sformatf("fp_c%0d.sel", c), int'(sel_o[1]), eo);
      chk($sformatf("fp_c%0d.gnt", c), int'(gnt_o[1]), 1 << eo);
    end

    // Randomized traffic with occasional reset, bursts of held requests and mode flips.
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      cycle();
    end

    rst = 1'b0; req = 3'b000;
    cycle();
    chk("maxrun_h8", maxrun[0], 8);
    chk("maxrun_h4", maxrun[1], 4);
    chk("err_multi_h8", int'(em_o[0]), 0);
    chk("err_range_h8", int'(er_o[0]), 0);
    chk("err_multi_h4", int'(em_o[1]), 0);
    chk("err_range_h4", int'(er_o[1]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
